mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-ported unified memory between the core's instruction-fetch path and its data-access (load/store) path. It grants one requester at a time, tracks a single outstanding transaction, and routes the memory response back to its owner. It sits between the fetch and memory stages of the pipeline and the memory/cache interface. Data accesses have priority, with an optional anti-starvation guard for fetch.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte strobe width is DATA_W/8
- STARVE_LIMIT, 4, consecutive denied-fetch grants before fetch is forced (only used with the guard compiled in)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch request accepted this cycle
- if_req_addr  in  ADDR_W  fetch address
- if_resp_valid  out  1  fetch read data valid
- if_resp_data  out  DATA_W  fetch read data
- d_req_valid  in  1  data request
- d_req_ready  out  1  data request accepted this cycle
- d_req_addr  in  ADDR_W  data address
- d_req_wdata  in  DATA_W  store data
- d_req_wstrb  in  DATA_W/8  byte strobes; all zero means load
- d_resp_valid  out  1  data response (load data, or store acknowledge)
- d_resp_data  out  DATA_W  load data; zero for stores
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_W  registered address
- mem_req_wdata  out  DATA_W  registered store data
- mem_req_wstrb  out  DATA_W/8  registered strobes; zero for fetches
- mem_resp_valid  in  1  memory response; exactly one per accepted request
- mem_resp_data  in  DATA_W  memory read data

## Operation
- The FSM has three states: IDLE, ISSUE and WAIT.
- **IDLE**
  - Grant logic is combinational on the valids.
  - If d_req_valid is high, assert d_req_ready. Otherwise, if if_req_valid is high, assert if_req_ready.
  - At most one ready is high in any cycle. Ready is only ever high in IDLE.
  - On a grant, latch addr/wdata/wstrb into the mem_req_* registers; fetch latches wstrb=0 and wdata=0.
  - Latch the owner bit and go to ISSUE.
- **ISSUE**
  - mem_req_valid=1 and the mem_req_* outputs are held stable.
  - On mem_req_ready, go to WAIT and drive mem_req_valid=0 from the next cycle.
- **WAIT**
  - On mem_resp_valid, pulse the owner's resp_valid for the same cycle (combinational pass-through).
  - if_resp_data and d_resp_data follow mem_resp_data; d_resp_data is forced to 0 when the latched wstrb is nonzero.
  - Go to IDLE.
- mem_resp_valid in IDLE or ISSUE is ignored and never forwarded.
- Only one transaction is outstanding at a time; there is no pipelining of requests.

## Timing
- Reset values:
  - State is IDLE; owner is fetch.
  - All ready/valid outputs are 0.
  - mem_req_addr, mem_req_wdata and mem_req_wstrb are 0.
  - The starvation counter is 0.
- Latency:
  - Grant is in cycle N (IDLE).
  - mem_req_valid is high from N+1.
  - The earliest response is in N+2, given ready at N+1.
  - The earliest next grant is in N+3.
- Memory must not return mem_resp_valid in the same cycle as mem_req_ready.
- A requester keeps valid and its payload stable until it sees ready; the arbiter samples the payload only in the ready cycle.
- Simultaneous valids in IDLE: data wins, unless the guard forces fetch.
- Reset mid-transaction returns to IDLE and drops the in-flight transaction. A late mem_resp_valid after reset is ignored.

## Configuration
- Macro: ARB_STARVE_GUARD_EN.
- **Defined:**
  - A counter (width clog2(STARVE_LIMIT+1)) increments on each data grant made while if_req_valid=1.
  - It clears on a fetch grant, and in any IDLE cycle with if_req_valid=0.
  - When the count equals STARVE_LIMIT and both valids are high, fetch is granted instead of data, and the counter clears.
- **Undefined:** no counter; strict data-over-fetch priority, so fetch may starve indefinitely.

## Test plan
- **Single fetch:** if_req_valid with addr 0x0000_1000; memory ready on the first ISSUE cycle and response 0x0000_0013 one cycle later.
  - if_req_ready is high in cycle 0.
  - mem_req_valid is high in cycle 1 with wstrb=0.
  - if_resp_valid pulses with data 0x13 in cycle 2.
  - d_resp_valid stays 0 throughout.
- **Store:** d_req addr 0x2000, wdata 0xDEADBEEF, wstrb 0xF.
  - mem_req_* carry exactly these values.
  - d_resp_valid pulses with d_resp_data=0 even though mem_resp_data=0xFFFFFFFF.
- **Contention:** both valids high in IDLE.
  - d_req_ready=1 and if_req_ready=0.
  - Fetch is granted in the IDLE cycle after the data response.
- **Backpressure:** mem_req_ready held low for 5 cycles.
  - mem_req_valid stays high and the address stays stable.
  - Both readies stay 0.
  - Stray mem_resp_valid pulses during ISSUE are not forwarded.
- **Reset mid-WAIT:** assert rst for 1 cycle, then a late mem_resp_valid in IDLE.
  - Both resp_valids stay 0 and all outputs are at their reset values.
  - The next request is granted normally.
- **Guard** (ARB_STARVE_GUARD_EN, STARVE_LIMIT=4): both valids held high continuously.
  - Grant order is D,D,D,D,F,D,D,D,D,F.
  - Without the macro, every grant is D.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
//
// Bundles every handshake/bus signal around the unified-memory arbiter:
// the instruction-fetch request/response pair, the data (load/store)
// request/response pair, and the single memory request/response port.
//
// Modports:
//   master - the arbiter's view. It drives the requester readies and
//            responses, and the memory request. It samples the requester
//            payloads and the memory handshake.
//   slave  - the surrounding system (fetch stage, data stage, memory), i.e.
//            the mirror image of master.
//
// Parameters: ADDR_W (address width), DATA_W (data width; strobes are
// DATA_W/8 bits wide).
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    // instruction-fetch side
    logic              if_req_valid;
    logic              if_req_ready;
    logic [ADDR_W-1:0] if_req_addr;
    logic              if_resp_valid;
    logic [DATA_W-1:0] if_resp_data;

    // data-access side
    logic              d_req_valid;
    logic              d_req_ready;
    logic [ADDR_W-1:0] d_req_addr;
    logic [DATA_W-1:0] d_req_wdata;
    logic [STRB_W-1:0] d_req_wstrb;
    logic              d_resp_valid;
    logic [DATA_W-1:0] d_resp_data;

    // memory side
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic [STRB_W-1:0] mem_req_wstrb;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;

    modport master (
        input  if_req_valid, if_req_addr,
        input  d_req_valid, d_req_addr, d_req_wdata, d_req_wstrb,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output if_req_ready, if_resp_valid, if_resp_data,
        output d_req_ready, d_resp_valid, d_resp_data,
        output mem_req_valid, mem_req_addr, mem_req_wdata, mem_req_wstrb
    );

    modport slave (
        output if_req_valid, if_req_addr,
        output d_req_valid, d_req_addr, d_req_wdata, d_req_wstrb,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  if_req_ready, if_resp_valid, if_resp_data,
        input  d_req_ready, d_resp_valid, d_resp_data,
        input  mem_req_valid, mem_req_addr, mem_req_wdata, mem_req_wstrb
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported unified memory between the instruction-fetch path
// and the data (load/store) path. It grants one requester at a time and keeps
// a single transaction outstanding. The memory response is routed back to the
// requester that owns the transaction. Data accesses win over fetch.
//
// Optional feature: define ARB_STARVE_GUARD_EN to add an anti-starvation
// counter. When fetch has been passed over STARVE_LIMIT times in a row while
// it was waiting, fetch is granted instead of data.
//
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - synchronous, active-high reset
//   bus  - mem_port_arbiter_if.master: fetch/data request+response pairs and
//          the memory request/response port
//
// Parameters: ADDR_W, DATA_W, STARVE_LIMIT (guard threshold).
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_arbiter_if.master   bus
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic              owner_d_reg, owner_d_next;   // 1 = data path owns the transaction
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic [STRB_W-1:0] wstrb_reg, wstrb_next;

    logic grant_d;
    logic grant_if;
    logic force_fetch;
    logic resp_fire;

`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt_reg, starve_cnt_next;

    assign force_fetch = (starve_cnt_reg == CNT_W'(STARVE_LIMIT))
                         && bus.d_req_valid && bus.if_req_valid;

    // Counts data grants that passed over a waiting fetch. It cannot exceed
    // STARVE_LIMIT: at the limit a contended cycle grants fetch and clears it.
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (state_reg == IDLE) begin
            if (grant_if || !bus.if_req_valid) begin
                starve_cnt_next = '0;
            end else if (grant_d) begin
                starve_cnt_next = starve_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_reg <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
        end
    end
`else
    assign force_fetch = 1'b0;
`endif

    // Grant is purely combinational on the valids and only possible in IDLE.
    // Reset also masks it so every ready reads 0 while rst is high.
    always_comb begin
        grant_d  = 1'b0;
        grant_if = 1'b0;
        if (state_reg == IDLE && !rst) begin
            if (bus.d_req_valid && !force_fetch) begin
                grant_d = 1'b1;
            end else if (bus.if_req_valid) begin
                grant_if = 1'b1;
            end
        end
    end

    // Next-state and payload capture
    always_comb begin
        state_next   = state_reg;
        owner_d_next = owner_d_reg;
        addr_next    = addr_reg;
        wdata_next   = wdata_reg;
        wstrb_next   = wstrb_reg;
        case (state_reg)
            IDLE: begin
                if (grant_d) begin
                    state_next   = ISSUE;
                    owner_d_next = 1'b1;
                    addr_next    = bus.d_req_addr;
                    wdata_next   = bus.d_req_wdata;
                    wstrb_next   = bus.d_req_wstrb;
                end else if (grant_if) begin
                    state_next   = ISSUE;
                    owner_d_next = 1'b0;
                    addr_next    = bus.if_req_addr;
                    wdata_next   = '0;
                    wstrb_next   = '0;
                end
            end
            ISSUE: begin
                if (bus.mem_req_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_resp_valid) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            owner_d_reg <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            owner_d_reg <= owner_d_next;
            addr_reg    <= addr_next;
            wdata_reg   <= wdata_next;
            wstrb_reg   <= wstrb_next;
        end
    end

    // A response is only accepted while waiting for one. A stray or late
    // mem_resp_valid in IDLE or ISSUE never reaches a requester.
    assign resp_fire = (state_reg == WAIT) && bus.mem_resp_valid && !rst;

    assign bus.d_req_ready   = grant_d;
    assign bus.if_req_ready  = grant_if;

    assign bus.mem_req_valid = (state_reg == ISSUE) && !rst;
    assign bus.mem_req_addr  = addr_reg;
    assign bus.mem_req_wdata = wdata_reg;
    assign bus.mem_req_wstrb = wstrb_reg;

    assign bus.if_resp_valid = resp_fire && !owner_d_reg;
    assign bus.d_resp_valid  = resp_fire && owner_d_reg;
    assign bus.if_resp_data  = bus.mem_resp_data;
    // A store completion carries no data, whatever the memory drives back.
    assign bus.d_resp_data   = (wstrb_reg != '0) ? '0 : bus.mem_resp_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter. A transaction-level reference
// model tracks the pending fetch/data requests, the transaction in flight and
// the run of passed-over fetches. It predicts the readies, the memory request
// and the routed responses every cycle. Directed scenarios come first, then
// a randomized traffic phase. Build with +define+ARB_STARVE_GUARD_EN to check
// the anti-starvation order.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;
    localparam int ADDR_W       = 32;
    localparam int DATA_W       = 32;
    localparam int SW           = DATA_W / 8;
    localparam int STARVE_LIMIT = 4;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD_ON = 1'b1;
`else
    localparam bit GUARD_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        bit                is_d;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [SW-1:0]     wstrb;
    } txn_t;

    int n_checks = 0;
    int n_pass   = 0;
    int n_txn    = 0;

    // requester-side stimulus (held until granted)
    bit                if_pend = 0;
    logic [ADDR_W-1:0] if_addr_p = '0;
    bit                d_pend = 0;
    logic [ADDR_W-1:0] d_addr_p = '0;
    logic [DATA_W-1:0] d_wdata_p = '0;
    logic [SW-1:0]     d_wstrb_p = '0;
    // memory-side stimulus for the next cycle
    bit                mem_rdy_in = 0;
    bit                mem_resp_in = 0;
    logic [DATA_W-1:0] mem_rdata_in = '0;

    // reference model
    bit   busy = 0;        // a transaction has been granted and not answered
    bit   accepted = 0;    // memory has taken the request
    int   starve = 0;      // data grants in a row while fetch was waiting
    txn_t cur;
    bit   grant_log[$];    // 1 = data grant, 0 = fetch grant

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // One clock cycle: drive inputs, check every output against the model,
    // then advance the model.
    task automatic step();
        bit exp_dr, exp_ir, force_f, got_resp;
        @(negedge clk);
        bus.if_req_valid   = if_pend;
        bus.if_req_addr    = if_addr_p;
        bus.d_req_valid    = d_pend;
        bus.d_req_addr     = d_addr_p;
        bus.d_req_wdata    = d_wdata_p;
        bus.d_req_wstrb    = d_wstrb_p;
        bus.mem_req_ready  = mem_rdy_in;
        bus.mem_resp_valid = mem_resp_in;
        bus.mem_resp_data  = mem_rdata_in;
        #1;
        force_f = GUARD_ON && (starve == STARVE_LIMIT) && d_pend && if_pend;
        exp_dr  = !busy && !rst && d_pend && !force_f;
        exp_ir  = !busy && !rst && if_pend && !exp_dr;
        check("d_req_ready", bus.d_req_ready, exp_dr);
        check("if_req_ready", bus.if_req_ready, exp_ir);
        check("mem_req_valid", bus.mem_req_valid, busy && !accepted && !rst);
        if (busy && !accepted) begin
            check("mem_req_addr", bus.mem_req_addr, cur.addr);
            check("mem_req_wdata", bus.mem_req_wdata, cur.wdata);
            check("mem_req_wstrb", bus.mem_req_wstrb, cur.wstrb);
        end
        got_resp = busy && accepted && mem_resp_in && !rst;
        check("d_resp_valid", bus.d_resp_valid, got_resp && cur.is_d);
        check("if_resp_valid", bus.if_resp_valid, got_resp && !cur.is_d);
        if (got_resp) begin
            n_txn++;
            if (cur.is_d)
                check("d_resp_data", bus.d_resp_data, (cur.wstrb != 0) ? '0 : mem_rdata_in);
            else
                check("if_resp_data", bus.if_resp_data, mem_rdata_in);
            $display("txn %0d owner=%s addr=%08h wstrb=%h rdata=%08h",
                     n_txn, cur.is_d ? "D" : "F", cur.addr, cur.wstrb, mem_rdata_in);
        end
        // model update at the coming rising edge
        if (rst) begin
            busy = 0; accepted = 0; starve = 0;
        end else if (!busy) begin
            if (exp_ir || !if_pend) starve = 0;
            else if (exp_dr) starve++;
            if (exp_dr) begin
                cur = '{1'b1, d_addr_p, d_wdata_p, d_wstrb_p};
                d_pend = 0; busy = 1; accepted = 0;
                grant_log.push_back(1'b1);
            end else if (exp_ir) begin
                cur = '{1'b0, if_addr_p, '0, '0};
                if_pend = 0; busy = 1; accepted = 0;
                grant_log.push_back(1'b0);
            end
        end else if (!accepted) begin
            if (mem_rdy_in) accepted = 1;
        end else if (mem_resp_in) begin
            busy = 0;
        end
    endtask

    // Memory side of one granted transaction: optional stall with stray
    // responses, accept, then answer in the following cycle.
    task automatic finish_txn(input int stall, input logic [DATA_W-1:0] rdata);
        for (int i = 0; i < stall; i++) begin
            mem_rdy_in = 0; mem_resp_in = (i % 2 == 0); mem_rdata_in = $urandom;
            step();
        end
        mem_rdy_in = 1; mem_resp_in = 0;
        step();
        mem_rdy_in = 0; mem_resp_in = 1; mem_rdata_in = rdata;
        step();
        mem_resp_in = 0;
    endtask

    initial begin
        logic [9:0] gv;
        logic [9:0] gv_exp;

        // ---- reset state ----
        step();
        step();
        check("rst mem_req_addr", bus.mem_req_addr, 0);
        check("rst mem_req_wdata", bus.mem_req_wdata, 0);
        check("rst mem_req_wstrb", bus.mem_req_wstrb, 0);
        rst = 0;

        // ---- single fetch ----
        if_pend = 1; if_addr_p = 32'h0000_1000;
        step();
        check("fetch grant cycle0", bus.if_req_ready, 1);
        mem_rdy_in = 1;
        step();
        check("fetch mem_req_valid cycle1", bus.mem_req_valid, 1);
        check("fetch mem_req_wstrb cycle1", bus.mem_req_wstrb, 0);
        mem_rdy_in = 0; mem_resp_in = 1; mem_rdata_in = 32'h0000_0013;
        step();
        check("fetch if_resp_valid cycle2", bus.if_resp_valid, 1);
        check("fetch if_resp_data cycle2", bus.if_resp_data, 32'h13);
        mem_resp_in = 0;

        // ---- store ----
        d_pend = 1; d_addr_p = 32'h2000; d_wdata_p = 32'hDEAD_BEEF; d_wstrb_p = 4'hF;
        step();
        mem_rdy_in = 1;
        step();
        check("store mem_req_addr", bus.mem_req_addr, 32'h2000);
        check("store mem_req_wdata", bus.mem_req_wdata, 32'hDEAD_BEEF);
        check("store mem_req_wstrb", bus.mem_req_wstrb, 4'hF);
        mem_rdy_in = 0; mem_resp_in = 1; mem_rdata_in = 32'hFFFF_FFFF;
        step();
        check("store d_resp_valid", bus.d_resp_valid, 1);
        check("store d_resp_data", bus.d_resp_data, 0);
        mem_resp_in = 0;

        // ---- contention, then backpressure on the fetch that follows ----
        if_pend = 1; if_addr_p = 32'h0000_3000;
        d_pend = 1; d_addr_p = 32'h0000_4000; d_wdata_p = 32'h1234_5678; d_wstrb_p = 4'h0;
        step();
        check("contend d_req_ready", bus.d_req_ready, 1);
        check("contend if_req_ready", bus.if_req_ready, 0);
        finish_txn(0, 32'hCAFE_0001);
        step();
        check("contend fetch next", bus.if_req_ready, 1);
        d_pend = 1; d_addr_p = 32'h0000_5000; d_wstrb_p = 4'h3;
        finish_txn(5, 32'hCAFE_0002);   // both readies must stay low while stalled
        step();                          // pending store granted now
        finish_txn(1, 32'hCAFE_0003);

        // ---- reset mid-WAIT ----
        if_pend = 1; if_addr_p = 32'h0000_6000;
        step();
        mem_rdy_in = 1;
        step();
        mem_rdy_in = 0;
        rst = 1;
        step();
        rst = 0;
        mem_resp_in = 1; mem_rdata_in = 32'hBAD0_BAD0;   // late response
        step();
        check("post-rst mem_req_addr", bus.mem_req_addr, 0);
        check("post-rst mem_req_wdata", bus.mem_req_wdata, 0);
        check("post-rst mem_req_wstrb", bus.mem_req_wstrb, 0);
        check("post-rst if_resp_valid", bus.if_resp_valid, 0);
        mem_resp_in = 0;
        if_pend = 1; if_addr_p = 32'h0000_7000;
        step();
        check("post-rst grant", bus.if_req_ready, 1);
        finish_txn(0, 32'h0000_7777);

        // ---- starvation order with both valids held ----
        step();                          // idle cycle without fetch clears history
        grant_log.delete();
        for (int g = 0; g < 10; g++) begin
            if (!if_pend) begin if_pend = 1; if_addr_p = $urandom; end
            if (!d_pend) begin d_pend = 1; d_addr_p = $urandom; d_wdata_p = $urandom; d_wstrb_p = '0; end
            step();
            if (!if_pend) begin if_pend = 1; if_addr_p = $urandom; end
            if (!d_pend) begin d_pend = 1; d_addr_p = $urandom; d_wdata_p = $urandom; d_wstrb_p = '0; end
            finish_txn(0, $urandom);
        end
        gv = '0;
        for (int i = 0; i < 10 && i < grant_log.size(); i++) gv = {gv[8:0], grant_log[i]};
        gv_exp = GUARD_ON ? 10'b11110_11110 : 10'b11111_11111;
        check("grant order", gv, gv_exp);
        check("grant count", grant_log.size(), 10);

        // ---- randomized traffic ----
        for (int c = 0; c < 600; c++) begin
            if (!if_pend && $urandom_range(0, 2) == 0) begin
                if_pend = 1; if_addr_p = $urandom;
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1; d_addr_p = $urandom; d_wdata_p = $urandom;
                d_wstrb_p = ($urandom_range(0, 1) == 1) ? SW'($urandom) : '0;
            end
            mem_rdata_in = $urandom;
            mem_rdy_in   = ($urandom_range(0, 1) == 1);
            if (busy && accepted)      mem_resp_in = ($urandom_range(0, 1) == 1);
            else if (busy)             mem_resp_in = !mem_rdy_in && ($urandom_range(0, 3) == 0);
            else                       mem_resp_in = ($urandom_range(0, 3) == 0);
            step();
        end
        mem_rdy_in = 0; mem_resp_in = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end
endmodule
